// File: rtl/pulse_req_arbiter.sv
// Round-robin arbiter for N raw level requesters, each filtered by a HOLD-cycle run qualifier.
// Optional forced release after TIMEOUT grant cycles when GRANT_TIMEOUT_EN is defined.
module pulse_req_arbiter #(
   parameter int N       = 4,
   parameter int HOLD    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req_in,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic         busy,
   output logic [N-1:0] pending,
   output logic [N-1:0] ovf,
   output logic         timeout
);

   localparam int CW = $clog2(HOLD + 1);
   localparam int LW = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state, state_next;
   logic [CW-1:0]  cnt [N];
   logic [N-1:0]   qual;
   logic [LW-1:0]  last, last_next;
   logic [N-1:0]   grant_next, grant_clear;
   logic           busy_next;
   logic           pick_valid;
   logic [LW-1:0]  pick_idx, scan_idx;

   if (N < 2 || N > 8 || HOLD < 1 || TIMEOUT < 1) begin : g_param_check
      $error("pulse_req_arbiter: parameter out of range");
   end

`ifdef GRANT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt, tcnt_next;
   logic          timeout_q, timeout_next;
`endif

   // Run-length qualifier: counts consecutive high samples, saturating at HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!req_in[i])
               cnt[i] <= '0;
            else if (cnt[i] < CW'(HOLD))
               cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++)
         qual[i] = req_in[i] && (cnt[i] == CW'(HOLD - 1));
   end

   // Scan downward so the channel closest after last is the one that sticks.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = N; k >= 1; k--) begin
         scan_idx = LW'((int'(last) + k) % N);
         if (pending[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_next  = state;
      grant_next  = grant;
      busy_next   = busy;
      last_next   = last;
      grant_clear = '0;
`ifdef GRANT_TIMEOUT_EN
      tcnt_next    = tcnt;
      timeout_next = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_next            = GRANT;
               grant_next            = '0;
               grant_next[pick_idx]  = 1'b1;
               busy_next             = 1'b1;
               last_next             = pick_idx;
               grant_clear[pick_idx] = 1'b1;
`ifdef GRANT_TIMEOUT_EN
               tcnt_next = '0;
`endif
            end
         end
         GRANT: begin
            if (done) begin
               state_next = IDLE;
               grant_next = '0;
               busy_next  = 1'b0;
            end
`ifdef GRANT_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT - 1)) begin
               state_next   = IDLE;
               grant_next   = '0;
               busy_next    = 1'b0;
               timeout_next = 1'b1;
            end else begin
               tcnt_next = tcnt + TW'(1);
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // A same-edge qualify keeps pending set even on the channel being granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= '0;
         busy    <= 1'b0;
         last    <= LW'(N - 1);
         pending <= '0;
         ovf     <= '0;
      end else begin
         state   <= state_next;
         grant   <= grant_next;
         busy    <= busy_next;
         last    <= last_next;
         pending <= (pending & ~grant_clear) | qual;
         ovf     <= ovf | (qual & pending & ~grant_clear);
      end
   end

`ifdef GRANT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt      <= '0;
         timeout_q <= 1'b0;
      end else begin
         tcnt      <= tcnt_next;
         timeout_q <= timeout_next;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_req_arbiter.sv
// Scoreboard bench for pulse_req_arbiter (N=4, HOLD=2, TIMEOUT=8): grant order is
// queued when requests are driven and popped as each new grant appears.
module tb_pulse_req_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req_in;
   logic       done;
   logic [3:0] grant;
   logic       busy;
   logic [3:0] pending;
   logic [3:0] ovf;
   logic       timeout;

   int checkCount = 0;
   int errorCount = 0;
   logic [3:0] expQ[$];
   logic [3:0] prevGrant;

   pulse_req_arbiter #(.N(4), .HOLD(2), .TIMEOUT(8)) dut (
      .clk(clk),
      .reset(reset),
      .req_in(req_in),
      .done(done),
      .grant(grant),
      .busy(busy),
      .pending(pending),
      .ovf(ovf),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Holds the mask for two edges, so every channel in it qualifies once.
   task automatic applyStimulus(input logic [3:0] mask);
      req_in = mask;
      stepClk();
      stepClk();
      req_in = 4'b0000;
   endtask

   task automatic serveOne();
      for (int k = 0; k < 50 && grant == 4'b0000; k++) stepClk();
      checkOutput("grant_seen", 32'(grant != 4'b0000), 32'(1));
      checkOutput("busy_in_grant", 32'(busy), 32'(1));
      stepClk();
      stepClk();
      done = 1'b1;
      stepClk();
      done = 1'b0;
      checkOutput("release_grant", 32'(grant), 32'(0));
      checkOutput("release_busy", 32'(busy), 32'(0));
   endtask

   // Each change to a nonzero grant must match the next queued expectation.
   always @(negedge clk) begin
      if (!reset && grant != 4'b0000 && grant != prevGrant) begin
         if (expQ.size() == 0)
            checkOutput("unexpected_grant", 32'(grant), 32'(0));
         else
            checkOutput("grant_order", 32'(grant), 32'(expQ.pop_front()));
      end
      prevGrant = grant;
   end

   initial begin
      reset  = 1'b1;
      req_in = 4'b0000;
      done   = 1'b0;
      stepClk();
      stepClk();
      checkOutput("reset_grant", 32'(grant), 32'(0));
      checkOutput("reset_busy", 32'(busy), 32'(0));
      checkOutput("reset_pending", 32'(pending), 32'(0));
      checkOutput("reset_ovf", 32'(ovf), 32'(0));
      checkOutput("reset_timeout", 32'(timeout), 32'(0));
      reset = 1'b0;

      // Glitch filter
      req_in = 4'b0001;
      stepClk();
      req_in = 4'b0000;
      repeat (5) stepClk();
      checkOutput("glitch_pending", 32'(pending), 32'(0));
      checkOutput("glitch_grant", 32'(grant), 32'(0));
      req_in = 4'b0001;
      stepClk();
      checkOutput("hold1_pending", 32'(pending), 32'(0));
      stepClk();
      checkOutput("hold2_pending", 32'(pending), 32'(4'b0001));
      checkOutput("hold2_grant", 32'(grant), 32'(0));
      req_in = 4'b0000;
      expQ.push_back(4'b0001);
      stepClk();
      checkOutput("first_grant", 32'(grant), 32'(4'b0001));
      checkOutput("first_busy", 32'(busy), 32'(1));
      checkOutput("first_pending_clr", 32'(pending), 32'(0));
      serveOne();

      // Simultaneous qualify with last=0
      expQ.push_back(4'b0010);
      expQ.push_back(4'b0100);
      req_in = 4'b0110;
      stepClk();
      stepClk();
      checkOutput("simul_pending", 32'(pending), 32'(4'b0110));
      stepClk();
      req_in = 4'b0000;
      checkOutput("simul_grant1", 32'(grant), 32'(4'b0010));
      checkOutput("simul_pending1", 32'(pending), 32'(4'b0100));
      stepClk();
      stepClk();
      done = 1'b1;
      stepClk();
      done = 1'b0;
      checkOutput("simul_gap", 32'(grant), 32'(0));
      stepClk();
      checkOutput("simul_grant2", 32'(grant), 32'(4'b0100));
      stepClk();
      stepClk();
      done = 1'b1;
      stepClk();
      done = 1'b0;
      checkOutput("simul_pending_end", 32'(pending), 32'(0));
      checkOutput("simul_ovf_end", 32'(ovf), 32'(0));

      // Round-robin from last=1
      expQ.push_back(4'b0010);
      applyStimulus(4'b0010);
      serveOne();
      expQ.push_back(4'b0001);
      expQ.push_back(4'b0010);
      applyStimulus(4'b0011);
      serveOne();
      serveOne();
      expQ.push_back(4'b0100);
      expQ.push_back(4'b1000);
      expQ.push_back(4'b0001);
      expQ.push_back(4'b0010);
      applyStimulus(4'b1111);
      for (int n = 0; n < 4; n++) serveOne();

      // Overflow on ch3 while ch0 holds the grant
      expQ.push_back(4'b0001);
      applyStimulus(4'b0001);
      stepClk();
      checkOutput("ovf_hold_grant", 32'(grant), 32'(4'b0001));
      applyStimulus(4'b1000);
      checkOutput("ovf_first_pend", 32'(pending), 32'(4'b1000));
      checkOutput("ovf_not_yet", 32'(ovf), 32'(0));
      stepClk();
      applyStimulus(4'b1000);
      checkOutput("ovf_flag", 32'(ovf), 32'(4'b1000));
      checkOutput("ovf_pending", 32'(pending), 32'(4'b1000));
      checkOutput("ovf_still_granted", 32'(grant), 32'(4'b0001));
      expQ.push_back(4'b1000);
      done = 1'b1;
      stepClk();
      done = 1'b0;
      checkOutput("ovf_release", 32'(grant), 32'(0));
      stepClk();
      checkOutput("ovf_merged_grant", 32'(grant), 32'(4'b1000));
      checkOutput("ovf_pending_clr", 32'(pending), 32'(0));
      serveOne();
      repeat (10) stepClk();
      checkOutput("ovf_no_extra_grant", 32'(grant), 32'(0));
      checkOutput("ovf_sticky", 32'(ovf), 32'(4'b1000));

      // Reset mid-grant
      expQ.push_back(4'b0100);
      applyStimulus(4'b0100);
      stepClk();
      checkOutput("rst_pre_grant", 32'(grant), 32'(4'b0100));
      applyStimulus(4'b0010);
      checkOutput("rst_pre_pending", 32'(pending), 32'(4'b0010));
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      checkOutput("rst_grant", 32'(grant), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_pending", 32'(pending), 32'(0));
      checkOutput("rst_ovf", 32'(ovf), 32'(0));
      expQ.push_back(4'b0001);
      expQ.push_back(4'b0010);
      applyStimulus(4'b0011);
      serveOne();
      serveOne();
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      expQ.push_back(4'b0001);
      expQ.push_back(4'b1000);
      applyStimulus(4'b1001);
      serveOne();
      serveOne();

      // Long grant: forced release only with the timeout option
      expQ.push_back(4'b0010);
      expQ.push_back(4'b1000);
      applyStimulus(4'b0010);
      stepClk();
      checkOutput("to_grant", 32'(grant), 32'(4'b0010));
      applyStimulus(4'b1000);
      repeat (5) stepClk();
      checkOutput("to_held", 32'(grant), 32'(4'b0010));
      checkOutput("to_no_pulse", 32'(timeout), 32'(0));
      stepClk();
`ifdef GRANT_TIMEOUT_EN
      checkOutput("to_drop", 32'(grant), 32'(0));
      checkOutput("to_busy", 32'(busy), 32'(0));
      checkOutput("to_pulse", 32'(timeout), 32'(1));
      stepClk();
      checkOutput("to_pulse_end", 32'(timeout), 32'(0));
      checkOutput("to_next_grant", 32'(grant), 32'(4'b1000));
`else
      checkOutput("to_still_held", 32'(grant), 32'(4'b0010));
      checkOutput("to_tied", 32'(timeout), 32'(0));
      done = 1'b1;
      stepClk();
      done = 1'b0;
      checkOutput("to_done_release", 32'(grant), 32'(0));
      stepClk();
      checkOutput("to_next_grant", 32'(grant), 32'(4'b1000));
`endif
      serveOne();

      repeat (5) stepClk();
      checkOutput("sb_empty", 32'(expQ.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
